// File: rtl/pal_pkg.sv
// Shared definitions for the PAL macrocell array: bitstream length and
// bit-position helpers for the AND plane, OR plane and macrocell fields.
package pal_pkg;

  // Each input contributes a true and a complement enable per product term.
  localparam int AND_FIELD_W = 2;
  // Each macrocell owns a two-bit field: REG select then INV.
  localparam int MC_FIELD_W  = 2;
  localparam int MC_REG_OFS  = 0;
  localparam int MC_INV_OFS  = 1;

  // Decoded macrocell configuration.
  typedef struct packed {
    logic reg_en;
    logic inv;
  } mc_cfg_t;

  // Total number of configuration bits.
  function automatic int pal_len(input int n, input int m, input int p);
    return AND_FIELD_W * n * p + p * m + MC_FIELD_W * m;
  endfunction

  // AND-plane enable for literal n (neg selects the complement) in term p.
  function automatic int and_bit(input int p, input int n, input bit neg, input int nn);
    return AND_FIELD_W * (p * nn + n) + (neg ? 1 : 0);
  endfunction

  // OR-plane connection of term p to output m.
  function automatic int or_bit(input int m, input int p, input int nn, input int pp);
    return AND_FIELD_W * nn * pp + m * pp + p;
  endfunction

  // Macrocell m registered-path select.
  function automatic int mc_reg_bit(input int m, input int nn, input int mm, input int pp);
    return AND_FIELD_W * nn * pp + pp * mm + MC_FIELD_W * m + MC_REG_OFS;
  endfunction

  // Macrocell m output inversion.
  function automatic int mc_inv_bit(input int m, input int nn, input int mm, input int pp);
    return AND_FIELD_W * nn * pp + pp * mm + MC_FIELD_W * m + MC_INV_OFS;
  endfunction

endpackage

// File: rtl/pal_cfg_chain.sv
// Serial configuration chain: L-bit shift register, load counter,
// load-complete flag and sticky overrun flag.
module pal_cfg_chain #(
  parameter int L = 29
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_en_i,
  input  logic         cfg_i,
  input  logic         cfg_clr_i,
  output logic [L-1:0] chain_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [L-1:0]  chain_q, chain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Next-state: restart clears status but keeps the chain; a shift past a
  // full load still moves the chain but marks the configuration corrupt.
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    if (cfg_clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end else if (cfg_en_i) begin
      chain_d = {cfg_i, chain_q[L-1:1]};
      if (cnt_q < CNT_FULL) begin
        cnt_d  = cnt_q + CNT_ONE;
        done_d = (cnt_q == (CNT_FULL - CNT_ONE));
      end else begin
        err_d  = 1'b1;
        done_d = 1'b0;
      end
    end else begin
      chain_d = chain_q;
    end
  end

  // Configuration state registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign chain_o = chain_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pal_macrocell_array.sv
// N-input, M-output, P-term programmable AND/OR array with per-output
// macrocells (registered/combinational select plus inversion), configured
// by a serial bitstream. Outputs stay low until a clean full load.
module pal_macrocell_array
  import pal_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 1,
  parameter int P = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CFG_EN,
  input  logic         CFG,
  input  logic         CFG_CLR,
  input  logic [N-1:0] INPUT_VARS,
  output logic [M-1:0] OUTPUT_VALS,
  output logic         CFG_DONE,
  output logic         CFG_ERR
);

  localparam int L = pal_len(N, M, P);

  logic [L-1:0] chain_s;
  logic         done_s;
  logic         err_s;
  logic [P-1:0] term_s;
  logic [M-1:0] comb_s;
  logic [M-1:0] mc_reg_s;
  logic [M-1:0] mc_d, mc_q;
  logic         out_en_s;

  pal_cfg_chain #(
    .L(L)
  ) u_cfg_chain (
    .clk_i     (CLK),
    .rst_i     (RST),
    .cfg_en_i  (CFG_EN),
    .cfg_i     (CFG),
    .cfg_clr_i (CFG_CLR),
    .chain_o   (chain_s),
    .done_o    (done_s),
    .err_o     (err_s)
  );

  // AND plane: a term needs at least one enabled literal, so an empty term
  // reads as 0 instead of the usual AND identity.
  for (genvar p = 0; p < P; p++) begin : g_term
    logic [N-1:0] lit_en_s;
    logic [N-1:0] lit_ok_s;
    for (genvar n = 0; n < N; n++) begin : g_lit
      localparam int TI = and_bit(p, n, 1'b0, N);
      localparam int FI = and_bit(p, n, 1'b1, N);
      assign lit_en_s[n] = chain_s[TI] | chain_s[FI];
      assign lit_ok_s[n] = (~chain_s[TI] | INPUT_VARS[n]) &
                           (~chain_s[FI] | ~INPUT_VARS[n]);
    end
    assign term_s[p] = (|lit_en_s) & (&lit_ok_s);
  end

  // OR plane and macrocell field decode per output.
  for (genvar m = 0; m < M; m++) begin : g_out
    logic [P-1:0] conn_s;
    mc_cfg_t      mc_cfg_s;
    for (genvar p = 0; p < P; p++) begin : g_conn
      assign conn_s[p] = chain_s[or_bit(m, p, N, P)];
    end
    assign mc_cfg_s.reg_en = chain_s[mc_reg_bit(m, N, M, P)];
    assign mc_cfg_s.inv    = chain_s[mc_inv_bit(m, N, M, P)];
    assign comb_s[m]       = (|(conn_s & term_s)) ^ mc_cfg_s.inv;
    assign mc_reg_s[m]     = mc_cfg_s.reg_en;
  end

  assign out_en_s = done_s & ~CFG_EN;

  // Macrocell flop next-state: track the combinational value only while the
  // array is live; any restart or gating flushes the flops to 0.
  always_comb begin
    mc_d = '0;
    if (CFG_CLR) begin
      mc_d = '0;
    end else if (out_en_s) begin
      mc_d = comb_s;
    end else begin
      mc_d = '0;
    end
  end

  // Macrocell flops with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mc_q <= '0;
    end else begin
      mc_q <= mc_d;
    end
  end

  assign OUTPUT_VALS = {M{out_en_s}} & ((mc_reg_s & mc_q) | (~mc_reg_s & comb_s));
  assign CFG_DONE    = done_s;
  assign CFG_ERR     = err_s;

endmodule

// File: doc/pal_macrocell_array.md
Name: pal_macrocell_array

Overview:
Parametrised successor to the PAL block: N-input, M-output, P-product-term AND/OR array with a per-output macrocell. Each macrocell selects a registered or combinational path and an optional output inversion. Configuration is a serial bitstream, gated by a shift enable on the free-running array clock. A bit counter reports load-complete and overrun status. Outputs are forced low until a complete, valid bitstream is loaded.

Parameters:
N, 4, number of input variables
M, 1, number of outputs
P, 3, number of product terms (shared by all outputs)
L (localparam), 2*N*P + P*M + 2*M, bitstream length (29 at defaults)

Ports:
CLK  input  1  array clock; config shift and macrocell registers
RST  input  1  asynchronous reset, active-high
CFG_EN  input  1  shift enable; one config bit accepted per CLK rising edge while high
CFG  input  1  serial config bit
CFG_CLR  input  1  synchronous restart of load: clears counter, CFG_DONE, CFG_ERR and macrocell flops; chain contents untouched
INPUT_VARS  input  N  array inputs
OUTPUT_VALS  output  M  array outputs
CFG_DONE  output  1  exactly L bits loaded since reset/CFG_CLR
CFG_ERR  output  1  sticky overrun flag

Behaviour:
- Reset (async, RST=1):
  - chain = 0, counter = 0, CFG_DONE = 0, CFG_ERR = 0, macrocell flops = 0.
  - OUTPUT_VALS = 0.
- Shift (CFG_EN=1, CFG_CLR=0): chain <= {CFG, chain[L-1:1]}. After L shifts, the k-th bit shifted (k=0 first) sits at chain[k].
- Counter:
  - Width clog2(L+1); increments per accepted shift while counter < L.
  - CFG_DONE goes high on the edge that accepts the L-th bit, i.e. visible the cycle after.
- Overrun (shift while counter == L):
  - Chain still shifts, so the configuration is corrupt.
  - CFG_ERR <= 1 (sticky), CFG_DONE <= 0, counter holds at L.
  - Only CFG_CLR or RST recovers.
- CFG_CLR priority: over CFG_EN in the same cycle; no shift occurs that cycle.
- Bit map, with A = 2*N*P and B = A + P*M:
  - AND plane: chain[2*(p*N+n)] enables true literal INPUT_VARS[n] in term p; chain[2*(p*N+n)+1] enables its complement.
  - Term p = AND of enabled literals. A term with no enabled literal evaluates to 0 (not 1).
  - OR plane: chain[A + m*P + p] connects term p to output m. sum_m = OR of connected terms; 0 if none.
  - Macrocell m: chain[B+2m] = REG (1 = registered), chain[B+2m+1] = INV.
- Datapath:
  - c_m = sum_m ^ INV_m, purely combinational from INPUT_VARS, zero latency.
  - Flop q_m <= c_m on every CLK edge while CFG_DONE=1 and CFG_EN=0; otherwise q_m <= 0.
  - OUTPUT_VALS[m] = CFG_DONE & ~CFG_EN & (REG_m ? q_m : c_m).
  - Registered path latency: 1 CLK.
- Gating: while CFG_DONE=0 or CFG_EN=1, all outputs are 0, including during overrun.
- Reset mid-load: discards partial bits; the next load starts from bit 0.
- Partial load: a load of fewer than L bits never sets CFG_DONE; outputs stay 0 indefinitely.

Decomposition:
- Package pal_pkg holds:
  - functions pal_len(N,M,P), and_bit(p,n,neg,N), or_bit(m,p,N,P), mc_reg_bit(m,N,M,P), mc_inv_bit(m,N,M,P)
  - localparams for macrocell field offsets
- Sub-module pal_cfg_chain holds the L-bit shift register, counter, CFG_DONE and CFG_ERR logic.
- The top level instantiates pal_cfg_chain plus the generate-based AND/OR planes and macrocells.

Test Plan (defaults N=4, M=1, P=3, L=29):
1. Reset check: assert RST mid-simulation -> OUTPUT_VALS=0, CFG_DONE=0, CFG_ERR=0 immediately, without waiting for a CLK edge.
2. Combinational load: shift 29 bits with chain[0]=1, chain[2]=1, chain[24]=1, all else 0 (term0 = IN0&IN1, combinational) -> CFG_DONE=1 one cycle after the 29th shift. Then INPUT_VARS=4'b0011 -> out 1 same cycle; 4'b0001 -> 0; 4'b1111 -> 1.
3. Registered load: same bits plus chain[27]=1 -> toggling INPUT_VARS 4'b0000->4'b0011 changes the output one CLK edge later, not before.
4. Inversion only: only chain[28]=1 -> out=1 for every INPUT_VARS value. Asserting CFG_EN forces out=0 while high.
5. Overrun and recovery: 30th shift -> CFG_ERR=1, CFG_DONE=0, out=0. Then CFG_CLR pulse -> CFG_ERR=0. Reload 29 bits of scenario 2 -> behaviour of scenario 2 restored.
6. Reset mid-load and priority: RST after 10 shifts, then full 29-bit load -> CFG_DONE after exactly 29 shifts. CFG_CLR and CFG_EN asserted together -> no shift, counter 0.
